// File: rtl/i2s_speaker_tx.sv
// I2S transmitter for the Pmod I2S2 DAC: MCLK=clk/4, SCK=clk/16, LRCK=clk/512.
// One left/right pair is captured per 512-clk frame at the sample_tick cycle.
module i2s_speaker_tx #(
    parameter int I2S_DELAY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] audio_in_left,
    input  logic [15:0] audio_in_right,
    output logic        sample_tick,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin
);

    logic [8:0]  r_div_cnt;
    logic [15:0] r_left;
    logic [15:0] r_right;
    logic [15:0] r_prev_right;

    logic        w_half;
    logic [3:0]  w_pos;
    logic [3:0]  w_bit;
    logic        w_sdin;
    logic        w_tick;

    assign w_tick = (r_div_cnt == 9'd511);
    assign w_half = r_div_cnt[8];
    assign w_pos  = r_div_cnt[7:4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt    <= '0;
            r_left       <= '0;
            r_right      <= '0;
            r_prev_right <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 9'd1;
            if (w_tick) begin
                r_prev_right <= r_right;
                r_left       <= audio_in_left;
                r_right      <= audio_in_right;
            end
        end
    end

    // Standard I2S sends the previous word's LSB in slot 0 of each half.
    always_comb begin
        w_bit  = '0;
        w_sdin = 1'b0;
        if (I2S_DELAY != 0) begin
            w_bit = 4'd0 - w_pos;
            if (w_pos == 4'd0)
                w_sdin = w_half ? r_left[0] : r_prev_right[0];
            else
                w_sdin = w_half ? r_right[w_bit] : r_left[w_bit];
        end else begin
            w_bit  = 4'd15 - w_pos;
            w_sdin = w_half ? r_right[w_bit] : r_left[w_bit];
        end
    end

    assign sample_tick = w_tick;
    assign audio_mclk  = r_div_cnt[1];
    assign audio_sck   = r_div_cnt[3];
    assign audio_lrck  = r_div_cnt[8];
    assign audio_sdin  = w_sdin;

endmodule
